// File: rtl/my_i2c_ip_s00_axi_pkg.sv
`timescale 1ns/1ps
// Shared register map, bus response code and I2C engine state encoding.
package my_i2c_ip_s00_axi_pkg;

  localparam logic [2:0] REG_DEV = 3'd0;
  localparam logic [2:0] REG_REG = 3'd1;
  localparam logic [2:0] REG_CNT = 3'd2;
  localparam logic [2:0] REG_TX  = 3'd3;
  localparam logic [2:0] REG_RX  = 3'd4;
  localparam logic [2:0] REG_SCR = 3'd5;
  localparam logic [2:0] REG_RD  = 3'd6;
  localparam logic [2:0] REG_WR  = 3'd7;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    IDLE, START, SEND_BYTE, GET_ACK, RSTART, RECV_BYTE, SEND_ACK, STOP
  } i2c_state_t;

  function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] lane);
    return word[{lane, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/my_i2c_ip_s00_axi_i2c_master_core.sv
`timescale 1ns/1ps
// Single-master I2C engine: each bit slot is four quarter periods (SCL low, low, high, high);
// SDA only moves at the first-to-second quarter boundary, ACK/data sampled entering the last quarter.
module i2c_master_core
  import my_i2c_ip_s00_axi_pkg::*;
#(
  parameter int CLK_DIV = 250
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_rd,
  input  logic        start_wr,
  input  logic [6:0]  dev_addr,
  input  logic [7:0]  reg_addr,
  input  logic [7:0]  byte_cnt,
  input  logic [31:0] tx_data,
  input  logic        sda_in,
  output logic        scl_oe,
  output logic        sda_oe,
  output logic        busy,
  output logic        nack,
  output logic        req_data_chunk,
  output logic        rx_vld,
  output logic [1:0]  rx_lane,
  output logic [7:0]  rx_byte
);

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

  i2c_state_t  state;
  logic [15:0] div_cnt;
  logic [1:0]  q;
  logic [2:0]  bit_cnt;
  logic [7:0]  byte_idx;
  logic [1:0]  phase;
  logic [7:0]  shreg;
  logic        is_read;
  logic        ack_ok;
  logic        last_byte;

  assign last_byte = (byte_idx + 8'd1) == byte_cnt;

  // phase: 0 = device address, 1 = register address, 2 = data (write) or device+R (read), 3 = read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;  div_cnt <= '0;  q <= '0;  bit_cnt <= '0;  byte_idx <= '0;  phase <= '0;
      shreg <= '0;  is_read <= 1'b0;  ack_ok <= 1'b0;  scl_oe <= 1'b0;  sda_oe <= 1'b0;
      busy <= 1'b0;  nack <= 1'b0;  req_data_chunk <= 1'b0;  rx_vld <= 1'b0;
      rx_lane <= '0;  rx_byte <= '0;
    end else begin
      req_data_chunk <= 1'b0;
      rx_vld <= 1'b0;
      if (state == IDLE) begin
        div_cnt <= '0;
        q <= '0;
        scl_oe <= 1'b0;
        sda_oe <= 1'b0;
        if (start_rd || start_wr) begin
          state <= START;  busy <= 1'b1;  nack <= 1'b0;  is_read <= start_rd;
          phase <= 2'd0;  byte_idx <= '0;
        end
      end else if (div_cnt != DIV_LAST) begin
        div_cnt <= div_cnt + 16'd1;
      end else begin
        div_cnt <= '0;
        q <= q + 2'd1;
        case (state)
          START: begin
            if (q == 2'd1) sda_oe <= 1'b1;
            if (q == 2'd3) begin
              scl_oe <= 1'b1;  state <= SEND_BYTE;  shreg <= {dev_addr, 1'b0};  bit_cnt <= 3'd7;
            end
          end
          SEND_BYTE: begin
            if (q == 2'd0) sda_oe <= ~shreg[7];
            if (q == 2'd1) scl_oe <= 1'b0;
            if (q == 2'd3) begin
              scl_oe <= 1'b1;
              if (bit_cnt == 3'd0) state <= GET_ACK;
              else begin
                shreg <= {shreg[6:0], 1'b0};
                bit_cnt <= bit_cnt - 3'd1;
              end
            end
          end
          GET_ACK: begin
            if (q == 2'd0) sda_oe <= 1'b0;
            if (q == 2'd1) scl_oe <= 1'b0;
            if (q == 2'd2) ack_ok <= !sda_in;
            if (q == 2'd3) begin
              scl_oe <= 1'b1;
              if (!ack_ok) begin
                nack <= 1'b1;
                state <= STOP;
              end else begin
                case (phase)
                  2'd0: begin
                    state <= SEND_BYTE;  shreg <= reg_addr;  bit_cnt <= 3'd7;  phase <= 2'd1;
                  end
                  2'd1: begin
                    if (byte_cnt == 8'd0) state <= STOP;
                    else if (is_read) state <= RSTART;
                    else begin
                      state <= SEND_BYTE;  shreg <= byte_lane(tx_data, 2'd0);
                      bit_cnt <= 3'd7;  phase <= 2'd2;
                    end
                  end
                  2'd2: begin
                    if (is_read) begin
                      state <= RECV_BYTE;  bit_cnt <= 3'd7;  phase <= 2'd3;
                    end else begin
                      byte_idx <= byte_idx + 8'd1;
                      if (byte_idx[1:0] == 2'd3) req_data_chunk <= 1'b1;
                      if (last_byte) state <= STOP;
                      else begin
                        state <= SEND_BYTE;  bit_cnt <= 3'd7;
                        shreg <= byte_lane(tx_data, byte_idx[1:0] + 2'd1);
                      end
                    end
                  end
                  default: state <= STOP;
                endcase
              end
            end
          end
          RSTART: begin
            if (q == 2'd0) sda_oe <= 1'b0;
            if (q == 2'd1) scl_oe <= 1'b0;
            if (q == 2'd2) sda_oe <= 1'b1;
            if (q == 2'd3) begin
              scl_oe <= 1'b1;  state <= SEND_BYTE;  shreg <= {dev_addr, 1'b1};
              bit_cnt <= 3'd7;  phase <= 2'd2;
            end
          end
          RECV_BYTE: begin
            if (q == 2'd0) sda_oe <= 1'b0;
            if (q == 2'd1) scl_oe <= 1'b0;
            if (q == 2'd2) shreg <= {shreg[6:0], sda_in};
            if (q == 2'd3) begin
              scl_oe <= 1'b1;
              if (bit_cnt == 3'd0) begin
                state <= SEND_ACK;  rx_vld <= 1'b1;  rx_lane <= byte_idx[1:0];  rx_byte <= shreg;
              end else begin
                bit_cnt <= bit_cnt - 3'd1;
              end
            end
          end
          SEND_ACK: begin
            if (q == 2'd0) sda_oe <= !last_byte;
            if (q == 2'd1) scl_oe <= 1'b0;
            if (q == 2'd3) begin
              scl_oe <= 1'b1;
              byte_idx <= byte_idx + 8'd1;
              if (byte_idx[1:0] == 2'd3 || last_byte) req_data_chunk <= 1'b1;
              if (last_byte) state <= STOP;
              else begin
                state <= RECV_BYTE;
                bit_cnt <= 3'd7;
              end
            end
          end
          STOP: begin
            if (q == 2'd0) sda_oe <= 1'b1;
            if (q == 2'd1) scl_oe <= 1'b0;
            if (q == 2'd2) sda_oe <= 1'b0;
            if (q == 2'd3) begin
              state <= IDLE;
              busy <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/my_i2c_ip_s00_axi.sv
`timescale 1ns/1ps
// AXI4-Lite register file (8 x 32) in front of the I2C engine; writes to the two
// trigger registers launch a transaction, the engine fills the RX register byte by byte.
module my_i2c_ip_s00_axi
  import my_i2c_ip_s00_axi_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int CLK_DIV = 250
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETN,
  inout  wire                               scl_io,
  inout  wire                               sda_io,
  output logic                              req_data_chunk,
  output logic                              busy,
  output logic                              nack,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY
);

  logic [C_S_AXI_DATA_WIDTH-1:0] regs [8];
  logic       aw_rdy, b_vld, ar_rdy, r_vld;
  logic       wr_en, rd_start;
  logic [2:0] wr_idx, rd_idx;
  logic       scl_oe, sda_oe, rx_vld;
  logic [1:0] rx_lane;
  logic [7:0] rx_byte;
  logic       unused_ok;

  assign wr_idx   = S_AXI_AWADDR[4:2];
  assign rd_idx   = S_AXI_ARADDR[4:2];
  assign wr_en    = aw_rdy && S_AXI_AWVALID && S_AXI_WVALID;
  assign rd_start = S_AXI_ARVALID && !ar_rdy && !r_vld;

  assign S_AXI_AWREADY = aw_rdy;
  assign S_AXI_WREADY  = aw_rdy;
  assign S_AXI_BVALID  = b_vld;
  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_ARREADY = ar_rdy;
  assign S_AXI_RVALID  = r_vld;
  assign S_AXI_RRESP   = RESP_OKAY;

  assign scl_io = scl_oe ? 1'b0 : 1'bz;
  assign sda_io = sda_oe ? 1'b0 : 1'bz;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      aw_rdy <= 1'b0;
      b_vld  <= 1'b0;
      ar_rdy <= 1'b0;
      r_vld  <= 1'b0;
      S_AXI_RDATA <= '0;
    end else begin
      aw_rdy <= S_AXI_AWVALID && S_AXI_WVALID && !aw_rdy && !b_vld;
      if (wr_en) b_vld <= 1'b1;
      else if (S_AXI_BREADY) b_vld <= 1'b0;
      ar_rdy <= rd_start;
      if (rd_start) begin
        r_vld <= 1'b1;
        S_AXI_RDATA <= regs[rd_idx];
      end else if (S_AXI_RREADY) begin
        r_vld <= 1'b0;
      end
    end
  end

  // An engine RX byte lands after the bus write so it wins on a same-cycle collision.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      if (wr_en) begin
        for (int b = 0; b < C_S_AXI_DATA_WIDTH/8; b++)
          if (S_AXI_WSTRB[b]) regs[wr_idx][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
      end
      if (rx_vld) regs[REG_RX][{rx_lane, 3'b000} +: 8] <= rx_byte;
    end
  end

  i2c_master_core #(.CLK_DIV(CLK_DIV)) u_core (
    .clk            (S_AXI_ACLK),
    .rst_n          (S_AXI_ARESETN),
    .start_rd       (wr_en && wr_idx == REG_RD),
    .start_wr       (wr_en && wr_idx == REG_WR),
    .dev_addr       (regs[REG_DEV][6:0]),
    .reg_addr       (regs[REG_REG][7:0]),
    .byte_cnt       (regs[REG_CNT][7:0]),
    .tx_data        (regs[REG_TX][31:0]),
    .sda_in         (sda_io),
    .scl_oe         (scl_oe),
    .sda_oe         (sda_oe),
    .busy           (busy),
    .nack           (nack),
    .req_data_chunk (req_data_chunk),
    .rx_vld         (rx_vld),
    .rx_lane        (rx_lane),
    .rx_byte        (rx_byte)
  );

endmodule

// File: tb/tb_my_i2c_ip_s00_axi.sv
`timescale 1ns/1ps
// Directed bench: AXI register vectors from a table, then I2C write/read/NACK/reset sequences
// observed through a bus monitor with an optional ACKing slave.
module tb_my_i2c_ip_s00_axi;

  localparam int DIV = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [4:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic        req_data_chunk, busy, nack;
  wire         scl_w, sda_w;

  pullup (scl_w);
  pullup (sda_w);

  logic slv_low = 1'b0;
  logic ack_en = 1'b0;
  assign sda_w = slv_low ? 1'b0 : 1'bz;

  my_i2c_ip_s00_axi #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5), .CLK_DIV(DIV)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .scl_io(scl_w), .sda_io(sda_w),
    .req_data_chunk(req_data_chunk), .busy(busy), .nack(nack),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
  );

  // Bus monitor + slave: counts START/STOP, collects bytes, ACKs in the 9th slot when enabled.
  logic [7:0] seen[$];
  int starts = 0, stops = 0, bitn = 0, pulses = 0;
  logic [7:0] sh = 8'h00;
  logic prev_scl = 1'b1, prev_sda = 1'b1;

  always @(scl_w or sda_w) begin
    if (scl_w && prev_scl && sda_w != prev_sda) begin
      if (!sda_w) starts++;
      else stops++;
      bitn = 0;
    end else if (scl_w && !prev_scl) begin
      if (bitn < 8) begin
        sh = {sh[6:0], sda_w};
        bitn++;
        if (bitn == 8) seen.push_back(sh);
      end else begin
        bitn = 0;
      end
    end else if (!scl_w && prev_scl) begin
      slv_low = ack_en && (bitn == 8);
    end
    prev_scl = scl_w;
    prev_sda = sda_w;
  end

  always @(posedge clk) if (req_data_chunk) pulses++;

  int n_chk = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           input bit chk);
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (awready) break;
    end
    check("awready_wready_together", {30'd0, awready, wready}, 32'h3);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    if (chk) check("bvalid_after_handshake", {31'd0, bvalid}, 32'h1);
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    if (chk) check("bvalid_cleared", {31'd0, bvalid}, 32'h0);
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] d, input bit chk);
    @(negedge clk);
    araddr = a; arvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (arready) break;
    end
    if (chk) check("arready_rvalid_together", {30'd0, arready, rvalid}, 32'h3);
    else check("arready", {31'd0, arready}, 32'h1);
    d = rdata;
    arvalid = 1'b0; rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    if (chk) check("rvalid_cleared", {31'd0, rvalid}, 32'h0);
  endtask

  task automatic wait_idle(input int max_cyc, input string name);
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge clk); #1;
      if (!busy) break;
    end
    check(name, {31'd0, busy}, 32'h0);
  endtask

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [31:0] rd;
    int base, pbase;

    vecs[0] = '{5'h14, 32'h0000ABCD, 4'b0011, 32'h0000ABCD};
    vecs[1] = '{5'h0C, 32'h000000FE, 4'b0001, 32'h000000FE};
    vecs[2] = '{5'h0C, 32'hFFFFFFFF, 4'b0010, 32'h0000FFFE};
    vecs[3] = '{5'h10, 32'h12345678, 4'b1111, 32'h12345678};
    vecs[4] = '{5'h10, 32'hAABBCCDD, 4'b1100, 32'hAABB5678};
    vecs[5] = '{5'h08, 32'h000000A5, 4'b1111, 32'h000000A5};
    vecs[6] = '{5'h04, 32'h1234567F, 4'b0101, 32'h0034007F};
    vecs[7] = '{5'h00, 32'h0000005B, 4'b1111, 32'h0000005B};

    rst_n = 1'b0;
    awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_axi_ready_valid", {27'd0, awready, wready, bvalid, arready, rvalid}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_resp", {28'd0, bresp, rresp}, 32'h0);
    check("rst_status", {29'd0, busy, nack, req_data_chunk}, 32'h0);
    check("rst_bus_released", {30'd0, scl_w, sda_w}, 32'h3);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      axi_read(5'(i * 4), rd, 1'b0);
      check($sformatf("rst_reg%0d", i), rd, 32'h0);
    end

    for (int i = 0; i < 8; i++) begin
      axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, i == 0);
      axi_read(vecs[i].addr, rd, i == 0);
      check($sformatf("tbl%0d_readback", i), rd, vecs[i].exp);
    end

    // Write transaction with no slave: device byte only, then NACK and STOP.
    axi_write(5'h04, 32'h0, 4'hF, 1'b0);
    axi_write(5'h08, 32'h0, 4'hF, 1'b0);
    base = seen.size();
    starts = 0; stops = 0;
    axi_write(5'h1C, 32'h88, 4'hF, 1'b0);
    check("wr_nack_busy_rise", {31'd0, busy}, 32'h1);
    wait_idle(1000, "wr_nack_busy_fall");
    check("wr_nack_sticky", {31'd0, nack}, 32'h1);
    check("wr_nack_byte_count", 32'(seen.size() - base), 32'd1);
    if (seen.size() > base) check("wr_nack_dev_byte", {24'd0, seen[base]}, 32'hB6);
    check("wr_nack_start_stop", {starts[15:0], stops[15:0]}, {16'd1, 16'd1});
    axi_read(5'h1C, rd, 1'b0);
    check("trigger_data_stored", rd, 32'h88);

    // Read trigger, then a write trigger while busy must be dropped.
    base = seen.size();
    axi_write(5'h18, 32'h99, 4'hF, 1'b0);
    check("rd_busy_rise", {31'd0, busy}, 32'h1);
    axi_write(5'h1C, 32'h77, 4'hF, 1'b0);
    check("rd_still_busy", {31'd0, busy}, 32'h1);
    wait_idle(1000, "rd_busy_fall");
    repeat (40) @(posedge clk);
    #1;
    check("busy_trigger_ignored", {31'd0, busy}, 32'h0);
    check("busy_trigger_bytes", 32'(seen.size() - base), 32'd1);
    axi_read(5'h1C, rd, 1'b0);
    check("busy_trigger_stored", rd, 32'h77);

    // Acknowledged write of 5 data bytes: lanes wrap and one chunk request after byte 4.
    ack_en = 1'b1;
    axi_write(5'h08, 32'd5, 4'hF, 1'b0);
    axi_write(5'h0C, 32'h44332211, 4'hF, 1'b0);
    base = seen.size();
    pbase = pulses;
    axi_write(5'h1C, 32'h1, 4'hF, 1'b0);
    wait_idle(3000, "wr5_busy_fall");
    check("wr5_nack", {31'd0, nack}, 32'h0);
    check("wr5_chunk_pulses", 32'(pulses - pbase), 32'd1);
    check("wr5_byte_count", 32'(seen.size() - base), 32'd7);
    if (seen.size() >= base + 7) begin
      check("wr5_bytes_0_3", {seen[base], seen[base+1], seen[base+2], seen[base+3]}, 32'hB6001122);
      check("wr5_bytes_4_6", {8'h00, seen[base+4], seen[base+5], seen[base+6]}, 32'h00334411);
    end

    // Single-byte read from a slave that leaves SDA released: 0xFF lands in RX lane 0.
    axi_write(5'h08, 32'd1, 4'hF, 1'b0);
    base = seen.size();
    pbase = pulses;
    starts = 0;
    axi_write(5'h18, 32'h0, 4'hF, 1'b0);
    wait_idle(2000, "rd1_busy_fall");
    check("rd1_nack", {31'd0, nack}, 32'h0);
    check("rd1_starts_incl_repeated", 32'(starts), 32'd2);
    check("rd1_chunk_pulses", 32'(pulses - pbase), 32'd1);
    if (seen.size() >= base + 4)
      check("rd1_bus_bytes", {seen[base], seen[base+1], seen[base+2], seen[base+3]}, 32'hB600B7FF);
    else
      check("rd1_byte_count", 32'(seen.size() - base), 32'd4);
    axi_read(5'h10, rd, 1'b0);
    check("rd1_rx_reg", rd, 32'hAABB56FF);

    // Asynchronous reset in the middle of the second byte of a write.
    axi_write(5'h08, 32'd5, 4'hF, 1'b0);
    base = seen.size();
    axi_write(5'h1C, 32'h1, 4'hF, 1'b0);
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      if (seen.size() > base && bitn == 4) break;
    end
    check("midbyte_reached", {31'd0, busy}, 32'h1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'h0);
    check("arst_bus_released", {30'd0, scl_w, sda_w}, 32'h3);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      axi_read(5'(i * 4), rd, 1'b0);
      check($sformatf("arst_reg%0d", i), rd, 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/my_i2c_ip_s00_axi.md
Name: my_i2c_ip_s00_axi

Overview:
AXI4-Lite slave register file (8 x 32-bit) that drives a single-master I2C engine with open-drain SCL/SDA.
Software loads device address, register address, byte count and TX data, then writes a trigger register to start an I2C write or read.
Status (busy, nack, data-chunk request) is exported on ports.
The block sits between the PS AXI interconnect and the board I2C pins.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI data width (only 32 supported)
C_S_AXI_ADDR_WIDTH, 5, AXI byte address width; register index = addr[4:2]
CLK_DIV, 250, ACLK cycles per quarter SCL period (100 MHz -> 100 kHz)

Ports:
S_AXI_ACLK  in  1  single clock
S_AXI_ARESETN  in  1  reset, asynchronous, active-low
scl_io  inout  1  I2C clock, open-drain (drive 0 or Z)
sda_io  inout  1  I2C data, open-drain
req_data_chunk  out  1  one-cycle pulse: TX word consumed / RX word filled (every 4 bytes)
busy  out  1  I2C transaction in progress
nack  out  1  sticky: slave NACKed during last transaction
S_AXI_AWADDR in 5; S_AXI_AWPROT in 3 (ignored); S_AXI_AWVALID in 1; S_AXI_AWREADY out 1
S_AXI_WDATA in 32; S_AXI_WSTRB in 4; S_AXI_WVALID in 1; S_AXI_WREADY out 1
S_AXI_BRESP out 2; S_AXI_BVALID out 1; S_AXI_BREADY in 1
S_AXI_ARADDR in 5; S_AXI_ARPROT in 3 (ignored); S_AXI_ARVALID in 1; S_AXI_ARREADY out 1
S_AXI_RDATA out 32; S_AXI_RRESP out 2; S_AXI_RVALID out 1; S_AXI_RREADY in 1

Behaviour:
- Reset: all registers 0; AWREADY/WREADY/BVALID/ARREADY/RVALID 0; RDATA 0; BRESP/RRESP always 00; busy, nack, req_data_chunk 0; SCL/SDA released (Z).
- Write channel: when AWVALID & WVALID & !AWREADY & !BVALID, assert AWREADY and WREADY together for exactly one cycle. Write reg[AWADDR[4:2]] on that edge, byte lanes masked by WSTRB. BVALID rises on the next edge and holds until BREADY, then clears.
- Read channel: when ARVALID & !ARREADY & !RVALID, load RDATA = reg[ARADDR[4:2]] and assert ARREADY and RVALID on the same edge. ARREADY lasts one cycle; RVALID holds until RREADY, then clears.
- Register map:
  - 0: device address [6:0]
  - 1: I2C register address [7:0]
  - 2: byte count [7:0]
  - 3: TX data, bytes sent LSB-first
  - 4: RX data, engine-written, software-writable
  - 5: scratch
  - 6: write = start READ
  - 7: write = start WRITE
  All registers read back as last written. Trigger data is stored but ignored; a trigger while busy is ignored.
- busy rises on the edge after the trigger write and falls one cycle after STOP completes. nack is cleared at each start.
- Timing: SCL period = 4*CLK_DIV ACLK cycles. SDA changes only while SCL is low. START = SDA falls while SCL high; STOP = SDA rises while SCL high. MSB first. ACK sampled at the 9th SCL high; SDA != 0 (including Z) counts as NACK.
- WRITE sequence: START, {addr,0}, reg addr, then count bytes from reg3 (byte index mod 4). After every 4th byte, pulse req_data_chunk. Then STOP.
- READ sequence: START, {addr,0}, reg addr, repeated START, {addr,1}, count bytes. Master ACKs each byte except the last, which gets a NACK. Each byte is shifted into reg4 at lane (index mod 4); pulse req_data_chunk after each 4th byte and after the final byte. Then STOP.
- count = 0: write sends address + reg then STOP; read skips the read phase.
- Any slave NACK: set nack, go to STOP, end the transaction.
- FSM states: IDLE, START, SEND_BYTE, GET_ACK, RSTART, RECV_BYTE, SEND_ACK, STOP.
- Asynchronous reset mid-transaction returns to IDLE and releases the bus immediately.

Decomposition:
- Package: register index constants (REG_DEV, REG_REG, REG_CNT, REG_TX, REG_RX, REG_SCR, REG_RD, REG_WR), FSM state enum, RESP_OKAY.
- One sub-module, i2c_master_core: FSM plus bit timing. The AXI register file stays in the top level.

Test Plan:
- Write 0xABCD to reg5 (addr 0x14, WSTRB 0011) with AW/W together -> AWREADY & WREADY high same cycle, BVALID then clears on BREADY; read 0x14 -> ARREADY & RVALID high together, RDATA = 0x0000ABCD.
- Write 0xFE to reg3 (WSTRB 0001) -> readback 0x000000FE; then write 0xFFFFFFFF with WSTRB 0010 -> readback 0x0000FFFE.
- reg0 = 0x5B, reg1 = 0, reg2 = 0, write 0x88 to reg7 -> busy = 1, START, byte 0xB6 on SDA; with no slave (SDA Z) nack = 1, STOP, busy returns 0.
- After busy = 0, write 0x99 to reg6 -> read transaction starts, busy = 1; a second reg7 write while busy -> ignored.
- Slave model ACKs, reg2 = 5, reg3 = 0x44332211, WRITE -> bytes 0xB6, 0x00, 0x11, 0x22, 0x33, 0x44, 0x11; req_data_chunk pulses once; nack = 0.
- Deassert S_AXI_ARESETN mid-byte -> busy = 0 and SCL/SDA = Z immediately; all registers read 0.
